// File: rtl/fp_mult_core.sv
// fp_mult_core: iterative radix-2 significand multiplier and normaliser for
// the binary32 multiply datapath. It accepts one operand pair over a
// valid/ready handshake. It then produces the normalised mantissa, the guard
// and sticky bits, the sign and the pre-round exponent for the rounding stage.
module fp_mult_core #(
    parameter int BIAS   = 127,
    parameter int MANT_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W:0]   mant_out,
    output logic              guard,
    output logic              sticky,
    output logic              sign,
    output logic [9:0]        exp_out,
    output logic              zero,
    output logic              special
);

    localparam int PW = 2 * MANT_W;
    localparam int CW = $clog2(MANT_W);
    localparam logic [CW-1:0] LAST = CW'(MANT_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        NORM,
        DONE
    } state_t;

    state_t            state, state_nx;
    logic [MANT_W-1:0] ma, mb;
    logic [PW-1:0]     acc;
    logic [CW-1:0]     cnt;
    logic [9:0]        exp_sum;
    logic              hid_a, hid_b;

    assign in_ready = (state == IDLE);
    assign hid_a    = (a[30:23] != 8'd0);
    assign hid_b    = (b[30:23] != 8'd0);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = MULT;
            MULT: if (cnt == LAST) state_nx = NORM;
            NORM: state_nx = DONE;
            DONE: if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add accumulation, normalisation, output hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            ma        <= '0;
            mb        <= '0;
            acc       <= '0;
            cnt       <= '0;
            exp_sum   <= '0;
            sign      <= 1'b0;
            zero      <= 1'b0;
            special   <= 1'b0;
            mant_out  <= '0;
            guard     <= 1'b0;
            sticky    <= 1'b0;
            exp_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ma      <= {hid_a, a[MANT_W-2:0]};
                        mb      <= {hid_b, b[MANT_W-2:0]};
                        sign    <= a[31] ^ b[31];
                        exp_sum <= {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'(BIAS);
                        zero    <= !hid_a || !hid_b;
                        special <= (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
                        acc     <= '0;
                        cnt     <= '0;
                    end
                end
                MULT: begin
                    if (mb[cnt]) acc <= acc + (PW'(ma) << cnt);
                    if (cnt != LAST) cnt <= cnt + 1'b1;
                end
                NORM: begin
                    if (zero) begin
                        mant_out <= '0;
                        guard    <= 1'b0;
                        sticky   <= 1'b0;
                        exp_out  <= '0;
                    end else if (acc[PW-1]) begin
                        mant_out <= {1'b0, acc[PW-1 -: MANT_W]};
                        guard    <= acc[MANT_W-1];
                        sticky   <= |acc[MANT_W-2:0];
                        exp_out  <= exp_sum + 10'd1;
                    end else begin
                        mant_out <= {1'b0, acc[PW-2 -: MANT_W]};
                        guard    <= acc[MANT_W-2];
                        sticky   <= |acc[MANT_W-3:0];
                        exp_out  <= exp_sum;
                    end
                end
                DONE: begin
                    // out_valid rises one cycle after DONE is entered and drops on the handshake
                    if (out_valid && out_ready) out_valid <= 1'b0;
                    else                        out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mult_core.sv
// Self-checking bench for fp_mult_core: directed cases plus random operands
// compared against an integer-arithmetic reference of the significand product.
module tb_fp_mult_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [24:0] mant_out;
    logic        guard, sticky, sign, zero, special;
    logic [9:0]  exp_out;

    int n_checks = 0;
    int n_fail   = 0;

    fp_mult_core #(.BIAS(127), .MANT_W(24)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .mant_out(mant_out), .guard(guard), .sticky(sticky),
        .sign(sign), .exp_out(exp_out), .zero(zero), .special(special)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: multiply the significands as integers and normalise the product
    task automatic model(input logic [31:0] ta, input logic [31:0] tb,
                         output logic [24:0] m, output logic g, output logic s,
                         output logic [9:0] e, output logic sg,
                         output logic z, output logic sp);
        longint unsigned ea, eb, pa, pb, p;
        longint          ex;
        ea = longint'(ta[30:23]);
        eb = longint'(tb[30:23]);
        pa = longint'(ta[22:0]) + ((ea != 0) ? 64'd8388608 : 64'd0);
        pb = longint'(tb[22:0]) + ((eb != 0) ? 64'd8388608 : 64'd0);
        p  = pa * pb;
        ex = longint'(ea) + longint'(eb) - 127;
        sg = ta[31] ^ tb[31];
        z  = (ea == 0) || (eb == 0);
        sp = (ea == 255) || (eb == 255);
        if (z) begin
            m = '0; g = 1'b0; s = 1'b0; e = '0;
        end else if (p >= 64'h8000_0000_0000) begin
            m = 25'(p / 64'h100_0000);
            g = ((p / 64'h80_0000) % 2) != 0;
            s = (p % 64'h80_0000) != 0;
            e = 10'(ex + 1);
        end else begin
            m = 25'(p / 64'h80_0000);
            g = ((p / 64'h40_0000) % 2) != 0;
            s = (p % 64'h40_0000) != 0;
            e = 10'(ex);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] ta, input logic [31:0] tb);
        logic [24:0] m; logic g, s, sg, z, sp; logic [9:0] e;
        model(ta, tb, m, g, s, e, sg, z, sp);
        check({tag, ".mant"}, 64'(mant_out), 64'(m));
        check({tag, ".guard"}, 64'(guard), 64'(g));
        check({tag, ".sticky"}, 64'(sticky), 64'(s));
        check({tag, ".exp"}, 64'(exp_out), 64'(e));
        check({tag, ".sign"}, 64'(sign), 64'(sg));
        check({tag, ".zero"}, 64'(zero), 64'(z));
        check({tag, ".special"}, 64'(special), 64'(sp));
    endtask

    // Issue one operation, check latency and results, optionally stall the output
    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input int stall);
        int lat;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        a = ta; b = tb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'd26);
        check_out(tag, ta, tb);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            check({tag, ".stall_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".stall_ready"}, 64'(in_ready), 64'd0);
            check_out({tag, ".stall"}, ta, tb);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, ".ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int seen;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.mant", 64'(mant_out), 64'd0);
        check("rst.exp", 64'(exp_out), 64'd0);
        check("rst.flags", 64'({guard, sticky, sign, zero, special}), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of MULT discards the operation
        a = 32'h3FC00000; b = 32'h3FC00000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("midrst.busy", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("midrst.in_ready", 64'(in_ready), 64'd1);
        check("midrst.outs", 64'({mant_out, exp_out, guard, sticky, sign, zero, special}), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midrst.no_out", 64'(seen), 64'd0);

        // Directed cases
        do_op("one",     32'h3F800000, 32'h3F800000, 0);
        check("one.mant_const", 64'(mant_out), 64'h0800000);
        do_op("onehalf", 32'h3FC00000, 32'h3FC00000, 0);
        check("onehalf.exp_const", 64'(exp_out), 64'd128);
        do_op("guard",   32'h3F800001, 32'hBFC00000, 0);
        check("guard.g_const", 64'(guard), 64'd1);
        do_op("zero",    32'h00000000, 32'h40000000, 0);
        do_op("special", 32'h7F800000, 32'h3F800000, 0);
        do_op("maxmant", 32'h3FFFFFFF, 32'h3FFFFFFF, 0);
        do_op("bp",      32'h40490FDB, 32'hC02DF854, 10);
        do_op("after_bp", 32'h3F800000, 32'h40400000, 0);

        // Random operands, occasionally forcing zero/special exponents
        for (int i = 0; i < 20; i++) begin
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra[30:23] = 8'h00;
                1: rb[30:23] = 8'hFF;
                default: ;
            endcase
            do_op("rand", ra, rb, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
